// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM word adapter: FSM states, lane geometry and
// the request/response word layouts.
package sdram_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = LANES * BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_RESP
  } adapter_state_t;

  typedef struct packed {
    logic              we;
    logic [LANES-1:0]  be;
    logic [WORD_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [WORD_W-1:0] rdata;
    logic              error;
  } rsp_t;

endpackage

// File: rtl/sdram_lane_pick.sv
// Picks the next enabled byte lane above the current one, or the lowest
// enabled lane when starting a new request.
module sdram_lane_pick
  import sdram_pkg::*;
(
  input  logic [LANES-1:0]  be,
  input  logic [LANE_W-1:0] lane,
  input  logic              start,
  output logic [LANE_W-1:0] next_lane,
  output logic              has_next
);

  always_comb begin
    next_lane = '0;
    has_next  = 1'b0;
    // Scan downward so the last qualifying hit is the lowest lane.
    for (int unsigned i = LANES; i > 0; i--) begin
      if (be[i-1] && (start || ((i - 1) > 32'(lane)))) begin
        next_lane = LANE_W'(i - 1);
        has_next  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_word_adapter.sv
// Host-side word front-end for the SDRAM byte core: splits 32-bit requests
// into per-byte core accesses and reassembles a single response.
module sdram_word_adapter
  import sdram_pkg::*;
#(
  parameter int unsigned HOST_ADDR_WIDTH = 24,
  parameter int unsigned HOST_DATA_WIDTH = 32,
  parameter int unsigned CORE_DATA_WIDTH = 8,
  parameter int unsigned ACK_TIMEOUT     = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [HOST_ADDR_WIDTH-1:0] req_addr,
  input  logic [HOST_DATA_WIDTH-1:0] req_wdata,
  input  logic [LANES-1:0]           req_be,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [HOST_DATA_WIDTH-1:0] rsp_rdata,
  output logic                       rsp_error,
  output logic                       core_wr,
  output logic                       core_rd,
  output logic [HOST_ADDR_WIDTH-1:0] core_addr,
  output logic [CORE_DATA_WIDTH-1:0] core_write_data,
  input  logic                       core_accept,
  input  logic                       core_ack,
  input  logic [CORE_DATA_WIDTH-1:0] core_read_data,
  input  logic                       core_error
);

  localparam int unsigned BASE_W  = HOST_ADDR_WIDTH - LANE_W;
  localparam int unsigned TIMER_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  adapter_state_t      state_q, state_d;
  req_t                req_q;
  rsp_t                rsp;
  logic [BASE_W-1:0]   base_q;
  logic [LANE_W-1:0]   lane_q;
  logic [WORD_W-1:0]   rdata_q;
  logic                error_q;
  logic [TIMER_W-1:0]  timer_q;
  logic [LANE_W-1:0]   next_lane;
  logic                has_next;
  logic                advance;
  logic                timeout;
  logic [LANES-1:0]    pick_be;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^req_addr[LANE_W-1:0];

  // In IDLE the picker looks at the incoming enables to find the first lane.
  assign pick_be = (state_q == ST_IDLE) ? req_be : req_q.be;

  sdram_lane_pick u_lane_pick (
    .be        (pick_be),
    .lane      (lane_q),
    .start     (state_q == ST_IDLE),
    .next_lane (next_lane),
    .has_next  (has_next)
  );

  assign core_addr       = {base_q, lane_q};
  assign core_write_data = req_q.wdata[{lane_q, 3'b000} +: BYTE_W];
  assign rsp_rdata       = rsp.rdata;
  assign rsp_error       = rsp.error;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    core_wr   = 1'b0;
    core_rd   = 1'b0;
    advance   = 1'b0;
    timeout   = 1'b0;
    rsp.rdata = req_q.we ? '0 : rdata_q;
    rsp.error = error_q;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = has_next ? ST_ISSUE : ST_RESP;
      end
      ST_ISSUE: begin
        core_wr = req_q.we;
        core_rd = ~req_q.we;
        if (core_accept) begin
          if (req_q.we || core_ack) advance = 1'b1;
          else                      state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (core_ack) begin
          advance = 1'b1;
        end else if ((ACK_TIMEOUT != 0) && (timer_q == TIMER_W'(ACK_TIMEOUT))) begin
          advance = 1'b1;
          timeout = 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (advance) state_d = has_next ? ST_ISSUE : ST_RESP;
    if (rst) begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      core_wr   = 1'b0;
      core_rd   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      base_q  <= '0;
      lane_q  <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            req_q   <= '{we: req_we, be: req_be, wdata: req_wdata};
            base_q  <= req_addr[HOST_ADDR_WIDTH-1:LANE_W];
            lane_q  <= next_lane;
            rdata_q <= '0;
            error_q <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (core_accept) begin
            timer_q <= '0;
            if (core_error) error_q <= 1'b1;
            if (!req_q.we && core_ack) rdata_q[{lane_q, 3'b000} +: BYTE_W] <= core_read_data;
          end
        end
        ST_WAIT_ACK: begin
          timer_q <= timer_q + 1'b1;
          if (core_ack) begin
            rdata_q[{lane_q, 3'b000} +: BYTE_W] <= core_read_data;
            if (core_error) error_q <= 1'b1;
          end else if (timeout) begin
            error_q <= 1'b1;
          end
        end
        default: ;
      endcase
      if (advance && has_next) lane_q <= next_lane;
    end
  end

endmodule
